test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter H_RESOLUTION, default 640, active pixels per line.
REQ-002 SHALL have parameter V_RESOLUTION, default 480, active lines per frame.
REQ-003 SHALL have parameter COLOR_BITS, default 8, bits per colour channel (range 1..12).
REQ-004 SHALL have parameter BOX_SIZE, default 32, bouncing-box edge length in pixels.
REQ-005 SHALL have port i_clk  input  1  pixel clock; all state on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port i_disp_enable  input  1  current x,y is an active pixel.
REQ-008 SHALL have port x  input  13  pixel column, 0..H_RESOLUTION-1 when enabled.
REQ-009 SHALL have port y  input  13  pixel row, 0..V_RESOLUTION-1 when enabled.
REQ-010 SHALL have port i_mode  input  3  requested pattern, sampled at frame end only.
REQ-011 SHALL have port o_rgb  output  3 x COLOR_BITS  element 0 red, 1 green, 2 blue.
REQ-012 SHALL have port o_de  output  1  i_disp_enable delayed to align with o_rgb.
REQ-013 SHALL have port o_frame_count  output  16  completed-frame counter.

Function
REQ-014 SHALL have fixed latency of 2 clocks: inputs at edge N produce o_rgb/o_de after edge N+2.
REQ-015 SHALL drive o_rgb to all zeros whenever o_de is 0.
REQ-016 SHALL define frame-end event FE = i_disp_enable && x==H_RESOLUTION-1 && y==V_RESOLUTION-1.
REQ-017 SHALL on FE: latch i_mode into active_mode, increment o_frame_count (wrap 0xFFFF->0), step box; pixels sampled after that edge use new state.
REQ-018 SHALL ignore i_mode changes between FE events (no mid-frame tearing).
REQ-019 Mode 0 colour bars SHALL split width into 8 bars of H_RESOLUTION/8 (last bar absorbs remainder): white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones.
REQ-020 Mode 1 grid SHALL output white where x%32==0, y%32==0, x==H_RESOLUTION-1 or y==V_RESOLUTION-1, else black.
REQ-021 Mode 2 checkerboard SHALL output white where (x[4]^y[4]^o_frame_count[5])==1, else black (phase inverts every 32 frames).
REQ-022 Mode 3 gray ramp SHALL output all channels = floor(x * 2^COLOR_BITS / H_RESOLUTION), saturated to 2^COLOR_BITS-1; intermediate width sufficient for no overflow.
REQ-023 Mode 4 bouncing box SHALL output white where bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE, else dark blue (blue = MSB set only).
REQ-024 Modes 5-7 SHALL output black.
REQ-025 Box state SHALL be bx (0..H_RESOLUTION-BOX_SIZE), by (0..V_RESOLUTION-BOX_SIZE), dir_x, dir_y (1 = increasing).
REQ-026 On FE each axis SHALL move 1 pixel in its direction; if that step would leave range, direction SHALL flip and position SHALL move 1 pixel opposite in same FE.
REQ-027 Both axes hitting limits on same FE SHALL both flip independently (corner bounce).
REQ-028 Box SHALL update on every FE regardless of active_mode.
REQ-029 FE with i_disp_enable low (x,y ignored) SHALL not occur; no state changes on disabled cycles except pipeline shift.

Reset
REQ-030 On i_rst_n low SHALL asynchronously clear o_rgb, o_de, pipeline registers, o_frame_count to 0, active_mode to 0, bx=by=0, dir_x=dir_y=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release the first FE restarts counting from 1.
REQ-032 After deassertion, outputs SHALL be valid from the 2nd rising edge onward.

Verification
REQ-033 Reset, mode 0, drive pixel (80,10) enabled -> 2 clocks later o_de=1, o_rgb=yellow (R=G=0xFF, B=0x00); pixel (639,10) -> black.
REQ-034 Mode 0 active, set i_mode=1 at line 100 -> remaining frame stays bars; after FE pixel (64,5) white, (65,5) black.
REQ-035 Mode 3, COLOR_BITS=8, x=0,320,639 -> gray 0x00, 0x80, 0xFF.
REQ-036 Mode 4, run 608 frames -> bx=608-? check: after frame 608 bx=608, dir_x=1; frame 609 -> dir_x=0, bx=607; by bounces at frame 448.
REQ-037 Run 65536 frames (or force counter 0xFFFF) then FE -> o_frame_count=0; mode 2 phase toggles at count 32.
REQ-038 Assert i_rst_n low for 1 cycle mid-line in mode 4 -> o_rgb=0, o_de=0 immediately, box at (0,0), active_mode=0.

Source files
------------

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: colour bars, grid, checkerboard, gray ramp and a bouncing box.
// The pattern is chosen per frame and the output trails the pixel inputs by two clocks.
module test_pattern_gen #(
  parameter int H_RESOLUTION = 640,
  parameter int V_RESOLUTION = 480,
  parameter int COLOR_BITS   = 8,
  parameter int BOX_SIZE     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_disp_enable,
  input  logic [12:0]                x,
  input  logic [12:0]                y,
  input  logic [2:0]                 i_mode,
  output logic [2:0][COLOR_BITS-1:0] o_rgb,
  output logic                       o_de,
  output logic [15:0]                o_frame_count
);

  localparam int BAR_W = (H_RESOLUTION / 8 > 0) ? H_RESOLUTION / 8 : 1;
  localparam logic [12:0] LAST_X = 13'(H_RESOLUTION - 1);
  localparam logic [12:0] LAST_Y = 13'(V_RESOLUTION - 1);
  localparam logic [12:0] BX_MAX = 13'(H_RESOLUTION - BOX_SIZE);
  localparam logic [12:0] BY_MAX = 13'(V_RESOLUTION - BOX_SIZE);
  localparam logic [COLOR_BITS-1:0] FULL = '1;
  localparam logic [COLOR_BITS-1:0] DARK = COLOR_BITS'(1) << (COLOR_BITS - 1);

  logic [2:0]                 active_mode;
  logic [12:0]                bx, by;
  logic                       dir_x, dir_y;
  logic [2:0][COLOR_BITS-1:0] rgb_s1, rgb_next;
  logic                       de_s1;
  logic                       fe;

  logic [12:0] bar_q;
  logic [2:0]  bar_idx;
  logic [2:0]  bar_on;
  logic [25:0] ramp_num, ramp_q;
  logic [COLOR_BITS-1:0] gray;
  logic        grid_on, check_on, box_on;

  assign fe = i_disp_enable && (x == LAST_X) && (y == LAST_Y);

  // Returns {dir, pos}; a step that would leave 0..lim reverses and moves one pixel back instead.
  function automatic logic [13:0] step_axis(input logic [12:0] pos, input logic dir,
                                            input logic [12:0] lim);
    if (lim == 13'd0) return {dir, 13'd0};
    if (dir) return (pos >= lim) ? {1'b0, pos - 13'd1} : {1'b1, pos + 13'd1};
    return (pos == 13'd0) ? {1'b1, 13'd1} : {1'b0, pos - 13'd1};
  endfunction

  always_comb begin
    bar_q    = x / 13'(BAR_W);
    bar_idx  = (bar_q > 13'd7) ? 3'd7 : bar_q[2:0];
    // bar_on is {blue, green, red}
    case (bar_idx)
      3'd0:    bar_on = 3'b111;
      3'd1:    bar_on = 3'b011;
      3'd2:    bar_on = 3'b110;
      3'd3:    bar_on = 3'b010;
      3'd4:    bar_on = 3'b101;
      3'd5:    bar_on = 3'b001;
      3'd6:    bar_on = 3'b100;
      default: bar_on = 3'b000;
    endcase
    ramp_num = 26'(x) << COLOR_BITS;
    ramp_q   = ramp_num / 26'(H_RESOLUTION);
    gray     = (ramp_q > 26'(FULL)) ? FULL : ramp_q[COLOR_BITS-1:0];
    grid_on  = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == LAST_X) || (y == LAST_Y);
    check_on = x[4] ^ y[4] ^ o_frame_count[5];
    box_on   = (x >= bx) && ({1'b0, x} < {1'b0, bx} + 14'(BOX_SIZE)) &&
               (y >= by) && ({1'b0, y} < {1'b0, by} + 14'(BOX_SIZE));

    rgb_next = '0;
    if (i_disp_enable) begin
      case (active_mode)
        3'd0: for (int c = 0; c < 3; c++) rgb_next[c] = bar_on[c] ? FULL : '0;
        3'd1: for (int c = 0; c < 3; c++) rgb_next[c] = grid_on ? FULL : '0;
        3'd2: for (int c = 0; c < 3; c++) rgb_next[c] = check_on ? FULL : '0;
        3'd3: for (int c = 0; c < 3; c++) rgb_next[c] = gray;
        3'd4: begin
          for (int c = 0; c < 3; c++) rgb_next[c] = box_on ? FULL : '0;
          if (!box_on) rgb_next[2] = DARK;
        end
        default: rgb_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_s1        <= '0;
      de_s1         <= 1'b0;
      o_rgb         <= '0;
      o_de          <= 1'b0;
      o_frame_count <= '0;
      active_mode   <= '0;
      bx            <= '0;
      by            <= '0;
      dir_x         <= 1'b1;
      dir_y         <= 1'b1;
    end else begin
      rgb_s1 <= rgb_next;
      de_s1  <= i_disp_enable;
      o_rgb  <= rgb_s1;
      o_de   <= de_s1;
      // The frame-end pixel itself is still rendered with the outgoing frame's state.
      if (fe) begin
        active_mode      <= i_mode;
        o_frame_count    <= o_frame_count + 16'd1;
        {dir_x, bx}      <= step_axis(bx, dir_x, BX_MAX);
        {dir_y, by}      <= step_axis(by, dir_y, BY_MAX);
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: table of colour-bar vectors plus hand-written
// sequences for mode switching, box bouncing, counter wrap and mid-frame reset.
module tb_test_pattern_gen;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            de;
  logic [12:0]     px, py;
  logic [2:0]      mode;
  logic [2:0][7:0] rgb;
  logic            ode;
  logic [15:0]     fc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       de;
    int         x;
    int         y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t bars[10];

  always #5 clk = ~clk;

  test_pattern_gen dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_disp_enable (de),
    .x             (px),
    .y             (py),
    .i_mode        (mode),
    .o_rgb         (rgb),
    .o_de          (ode),
    .o_frame_count (fc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where the pixel reaches the output.
  task automatic chk_pix(input string name, input int ax, input int ay, input logic d,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    de = d; px = 13'(ax); py = 13'(ay);
    @(posedge clk); #1;
    de = 1'b0; px = '0; py = '0;
    @(posedge clk); #1;
    $display("pix %s (%0d,%0d) de=%0b rgb=%h_%h_%h fc=%0d", name, ax, ay, ode,
             rgb[0], rgb[1], rgb[2], fc);
    chk({name, ".de"}, 32'(ode), 32'(d));
    chk({name, ".rgb"}, {8'd0, rgb[0], rgb[1], rgb[2]}, {8'd0, er, eg, eb});
  endtask

  task automatic do_fe();
    de = 1'b1; px = 13'd639; py = 13'd479;
    @(posedge clk); #1;
    de = 1'b0; px = '0; py = '0;
  endtask

  initial begin
    bars[0] = '{1'b1,  80, 10, 8'hFF, 8'hFF, 8'h00};
    bars[1] = '{1'b1,   0,  0, 8'hFF, 8'hFF, 8'hFF};
    bars[2] = '{1'b1,  79, 10, 8'hFF, 8'hFF, 8'hFF};
    bars[3] = '{1'b1, 160, 20, 8'h00, 8'hFF, 8'hFF};
    bars[4] = '{1'b1, 240, 30, 8'h00, 8'hFF, 8'h00};
    bars[5] = '{1'b1, 320, 40, 8'hFF, 8'h00, 8'hFF};
    bars[6] = '{1'b1, 400, 50, 8'hFF, 8'h00, 8'h00};
    bars[7] = '{1'b1, 480, 60, 8'h00, 8'h00, 8'hFF};
    bars[8] = '{1'b1, 639, 10, 8'h00, 8'h00, 8'h00};
    bars[9] = '{1'b0,  80, 10, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b1; de = 1'b0; px = '0; py = '0; mode = 3'd0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset.de", 32'(ode), 32'd0);
    chk("reset.rgb", 32'(rgb), 32'd0);
    chk("reset.fc", 32'(fc), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      chk_pix($sformatf("bars%0d", i), bars[i].x, bars[i].y, bars[i].de,
              bars[i].r, bars[i].g, bars[i].b);

    // Mode request mid-frame must wait for the frame end.
    mode = 3'd1;
    chk_pix("mid_req", 65, 100, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    do_fe();
    chk("fc1", 32'(fc), 32'd1);
    chk_pix("grid64", 64, 5, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("grid65", 65, 5, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_pix("grid_rt", 639, 5, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("grid_bt", 65, 479, 1'b1, 8'hFF, 8'hFF, 8'hFF);

    mode = 3'd3;
    do_fe();
    chk_pix("gray0", 0, 7, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_pix("gray5", 5, 7, 1'b1, 8'h02, 8'h02, 8'h02);
    chk_pix("gray320", 320, 7, 1'b1, 8'h80, 8'h80, 8'h80);
    chk_pix("gray639", 639, 7, 1'b1, 8'hFF, 8'hFF, 8'hFF);

    mode = 3'd2;
    do_fe();
    chk_pix("chk16_0", 16, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("chk0_0", 0, 0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_pix("chk16_16", 16, 16, 1'b1, 8'h00, 8'h00, 8'h00);
    chk_pix("chk0_16", 0, 16, 1'b1, 8'hFF, 8'hFF, 8'hFF);

    // Box has stepped on every frame end so far: 4 frames -> (4,4).
    mode = 3'd4;
    do_fe();
    chk_pix("box_in", 4, 4, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("box_l", 3, 4, 1'b1, 8'h00, 8'h00, 8'h80);
    chk_pix("box_br", 35, 35, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("box_r", 36, 4, 1'b1, 8'h00, 8'h00, 8'h80);
    chk_pix("box_b", 4, 36, 1'b1, 8'h00, 8'h00, 8'h80);

    for (int i = 0; i < 604; i++) do_fe();
    chk("fc608", 32'(fc), 32'd608);
    // Frame 608: bx at right limit 608; by bounced at 449 and is now 896-608 = 288.
    chk_pix("f608_in", 608, 288, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("f608_l", 607, 288, 1'b1, 8'h00, 8'h00, 8'h80);
    chk_pix("f608_c", 639, 319, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    do_fe();
    chk_pix("f609_in", 607, 287, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("f609_r", 639, 287, 1'b1, 8'h00, 8'h00, 8'h80);
    chk_pix("f609_l", 606, 287, 1'b1, 8'h00, 8'h00, 8'h80);

    // Count 610 has bit 5 set, so the checkerboard phase is inverted.
    mode = 3'd2;
    do_fe();
    chk_pix("chkinv0", 0, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("chkinv16", 16, 0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Box kept moving during the checkerboard frame: frame 611 -> (605,285).
    mode = 3'd4;
    do_fe();
    chk_pix("f611_in", 605, 285, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("f611_l", 604, 285, 1'b1, 8'h00, 8'h00, 8'h80);
    chk_pix("f611_t", 605, 284, 1'b1, 8'h00, 8'h00, 8'h80);

    for (int i = 0; i < 64924; i++) do_fe();
    chk("fc_ffff", 32'(fc), 32'hFFFF);
    do_fe();
    chk("fc_wrap", 32'(fc), 32'd0);
    $display("counter wrap fc=%0d", fc);

    // Reset mid-line while a pixel is in flight.
    de = 1'b1; px = 13'd10; py = 13'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst.de", 32'(ode), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted de=%0b rgb=%h fc=%0d", ode, rgb, fc);
    chk("rst.de", 32'(ode), 32'd0);
    chk("rst.rgb", 32'(rgb), 32'd0);
    chk("rst.fc", 32'(fc), 32'd0);
    de = 1'b0; px = '0; py = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_pix("post_rst_bars", 100, 100, 1'b1, 8'hFF, 8'hFF, 8'h00);
    do_fe();
    chk("post_rst_fc", 32'(fc), 32'd1);
    chk_pix("post_rst_box", 1, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk_pix("post_rst_out", 0, 1, 1'b1, 8'h00, 8'h00, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
